// File: rtl/cic_comb_decim_if.sv
// Sample stream bundle for the CIC decimation/comb section.
// The master side produces integrator samples and consumes filtered output;
// the slave side is the comb block itself.
interface cic_comb_decim_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] x;
    logic             in_valid;
    logic [WIDTH-1:0] y;
    logic             y_valid;

    modport master (
        output x,
        output in_valid,
        input  y,
        input  y_valid
    );

    modport slave (
        input  x,
        input  in_valid,
        output y,
        output y_valid
    );
endinterface

// File: rtl/cic_comb_decim.sv
// CIC decimator back end: keeps one of every R valid integrator samples and
// runs it through N comb stages y(n) = x(n) - x(n-M) at the decimated rate.
// All arithmetic wraps modulo 2^WIDTH so integrator overflow cancels here.
// A valid token walks one stage per clock; delay lines only move with it.
module cic_comb_decim #(
    parameter int WIDTH = 16,
    parameter int R     = 4,
    parameter int N     = 3,
    parameter int M     = 1
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                clr,
    cic_comb_decim_if.slave     bus
);

    localparam int CW = (R > 1) ? $clog2(R) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(R - 1);

    // Decimation counter and strobe
    logic [CW-1:0] cnt_q, cnt_d;
    logic          strobe;

    // s_q[0] is the captured sample d0, s_q[k] is the output of comb stage k
    logic [N:0][WIDTH-1:0]         s_q, s_d;
    // z_q[k][0] is the newest past input of stage k, z_q[k][M-1] the oldest
    logic [N:1][M-1:0][WIDTH-1:0]  z_q, z_d;
    // Token valid shift register, one bit per stage boundary
    logic [N:0]                    vld_pipe_q, vld_pipe_d;

    // Strobe on the R-th valid sample; counter only moves on valid input
    always_comb begin
        strobe = bus.in_valid && (cnt_q == CNT_LAST);
        cnt_d  = cnt_q;
        if (bus.in_valid) begin
            cnt_d = strobe ? '0 : cnt_q + CW'(1);
        end
    end

    // Comb datapath next state: each stage updates only when a token enters it
    always_comb begin
        s_d        = s_q;
        z_d        = z_q;
        vld_pipe_d = {vld_pipe_q[N-1:0], strobe};
        if (strobe) begin
            s_d[0] = bus.x;
        end
        for (int k = 1; k <= N; k++) begin
            if (vld_pipe_q[k-1]) begin
                s_d[k]    = s_q[k-1] - z_q[k][M-1];
                z_d[k][0] = s_q[k-1];
                for (int j = 1; j < M; j++) begin
                    z_d[k][j] = z_q[k][j-1];
                end
            end
        end
    end

    // Counter register; clear wins over any concurrent strobe
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Pipeline registers; clear drops in-flight tokens and zeroes history
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s_q        <= '0;
            z_q        <= '0;
            vld_pipe_q <= '0;
        end else if (clr) begin
            s_q        <= '0;
            z_q        <= '0;
            vld_pipe_q <= '0;
        end else begin
            s_q        <= s_d;
            z_q        <= z_d;
            vld_pipe_q <= vld_pipe_d;
        end
    end

    // Output holds the last stage result between strobes
    assign bus.y       = s_q[N];
    assign bus.y_valid = vld_pipe_q[N];

endmodule

// File: tb/tb_cic_comb_decim.sv
// Self-checking bench: four differently parameterised instances share one
// stimulus stream and are compared against a closed-form CIC model
// (N-th order M-lag difference of the kept samples, modulo 2^WIDTH).
module tb_cic_comb_decim;

    localparam int NC = 4;
    localparam int CW_[NC] = '{8, 8, 8, 16};
    localparam int CR_[NC] = '{4, 4, 4, 3};
    localparam int CN_[NC] = '{1, 2, 1, 3};
    localparam int CM_[NC] = '{1, 1, 2, 1};

    logic        clk;
    logic        rstn;
    logic        clr;
    logic        iv;
    logic [15:0] xd;

    int n_vec;
    int n_err;
    int edge_n;

    cic_comb_decim_if #(.WIDTH(8))  if0 ();
    cic_comb_decim_if #(.WIDTH(8))  if1 ();
    cic_comb_decim_if #(.WIDTH(8))  if2 ();
    cic_comb_decim_if #(.WIDTH(16)) if3 ();

    assign if0.x = xd[7:0];  assign if0.in_valid = iv;
    assign if1.x = xd[7:0];  assign if1.in_valid = iv;
    assign if2.x = xd[7:0];  assign if2.in_valid = iv;
    assign if3.x = xd;       assign if3.in_valid = iv;

    cic_comb_decim #(.WIDTH(8),  .R(4), .N(1), .M(1)) u0 (.clk(clk), .rstn(rstn), .clr(clr), .bus(if0));
    cic_comb_decim #(.WIDTH(8),  .R(4), .N(2), .M(1)) u1 (.clk(clk), .rstn(rstn), .clr(clr), .bus(if1));
    cic_comb_decim #(.WIDTH(8),  .R(4), .N(1), .M(2)) u2 (.clk(clk), .rstn(rstn), .clr(clr), .bus(if2));
    cic_comb_decim #(.WIDTH(16), .R(3), .N(3), .M(1)) u3 (.clk(clk), .rstn(rstn), .clr(clr), .bus(if3));

    logic [15:0] y_o [NC];
    logic        yv_o[NC];
    assign y_o[0] = {8'h00, if0.y};  assign yv_o[0] = if0.y_valid;
    assign y_o[1] = {8'h00, if1.y};  assign yv_o[1] = if1.y_valid;
    assign y_o[2] = {8'h00, if2.y};  assign yv_o[2] = if2.y_valid;
    assign y_o[3] = if3.y;           assign yv_o[3] = if3.y_valid;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    int     cnt_m [NC];
    longint hist  [NC][8];   // kept samples, hist[c][0] newest
    bit     sv    [NC][16];  // output due at edge index (mod 16)
    longint sy    [NC][16];
    longint last_y[NC];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    function automatic longint binom(input int n, input int k);
        longint r = 1;
        for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
        return r;
    endfunction

    function automatic longint msk(input int c);
        return (longint'(1) << CW_[c]) - 1;
    endfunction

    task automatic model_clr(input int c);
        cnt_m[c]  = 0;
        last_y[c] = 0;
        for (int i = 0; i < 8; i++)  hist[c][i] = 0;
        for (int i = 0; i < 16; i++) begin sv[c][i] = 0; sy[c][i] = 0; end
    endtask

    // Apply inputs for the next edge e and update the model accordingly
    task automatic model_in(input int c, input int e, input logic v, input logic [15:0] xv, input logic cl);
        longint acc;
        int     due;
        if (cl) begin
            model_clr(c);
        end else if (v) begin
            if (cnt_m[c] == CR_[c] - 1) begin
                for (int i = 7; i > 0; i--) hist[c][i] = hist[c][i-1];
                hist[c][0] = longint'(xv) & msk(c);
                acc = 0;
                for (int i = 0; i <= CN_[c]; i++) begin
                    if (i % 2 == 1) acc = acc - binom(CN_[c], i) * hist[c][i*CM_[c]];
                    else            acc = acc + binom(CN_[c], i) * hist[c][i*CM_[c]];
                end
                due = (e + CN_[c]) % 16;
                sv[c][due] = 1;
                sy[c][due] = acc & msk(c);
            end
            cnt_m[c] = (cnt_m[c] + 1) % CR_[c];
        end
    endtask

    task automatic model_chk(input int c);
        int idx = edge_n % 16;
        if (sv[c][idx]) begin
            chk($sformatf("c%0d y_valid", c), 32'(yv_o[c]), 32'd1);
            chk($sformatf("c%0d y", c), 32'(y_o[c]), 32'(sy[c][idx]));
            last_y[c] = sy[c][idx];
            sv[c][idx] = 0;
        end else begin
            chk($sformatf("c%0d idle y_valid", c), 32'(yv_o[c]), 32'd0);
            chk($sformatf("c%0d hold y", c), 32'(y_o[c]), 32'(last_y[c]));
        end
    endtask

    // One clock: drive at negedge, model, step the edge, check at next negedge
    task automatic cyc(input logic v, input logic [15:0] xv, input logic cl);
        iv = v; xd = xv; clr = cl;
        for (int c = 0; c < NC; c++) model_in(c, edge_n + 1, v, xv, cl);
        @(posedge clk);
        edge_n++;
        @(negedge clk);
        for (int c = 0; c < NC; c++) model_chk(c);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 16'h0, 1'b0);
    endtask

    task automatic zero_chk(input string tag);
        for (int c = 0; c < NC; c++) begin
            chk($sformatf("%s c%0d y", tag, c), 32'(y_o[c]), 32'd0);
            chk($sformatf("%s c%0d y_valid", tag, c), 32'(yv_o[c]), 32'd0);
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0; edge_n = 0;
        rstn = 1'b0; clr = 1'b0; iv = 1'b0; xd = '0;
        for (int c = 0; c < NC; c++) model_clr(c);
        repeat (3) @(negedge clk);
        zero_chk("reset");
        rstn = 1'b1;

        // Ramp with in_valid every cycle
        for (int i = 0; i < 24; i++) cyc(1'b1, 16'(i), 1'b0);
        drain(4);

        // Wrap: kept samples 250 then 4 on the R=4 instances
        cyc(1'b0, 16'h0, 1'b1);
        for (int i = 0; i < 8; i++) cyc(1'b1, (i < 4) ? 16'(247 + i) : ((i == 7) ? 16'd4 : 16'd200), 1'b0);
        drain(4);

        // Gapped input: valid every 3rd cycle, same ramp values
        cyc(1'b0, 16'h0, 1'b1);
        for (int i = 0; i < 60; i++) cyc(i % 3 == 0, 16'(i / 3), 1'b0);
        drain(4);

        // Kept samples 10, 20, 30, 40
        cyc(1'b0, 16'h0, 1'b1);
        for (int i = 0; i < 16; i++) cyc(1'b1, 16'(10 * (i / 4 + 1)), 1'b0);
        drain(4);

        // Clear landing on a strobe cycle
        cyc(1'b0, 16'h0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b1, 16'(50 + i), 1'b0);
        cyc(1'b1, 16'd99, 1'b1);
        for (int i = 0; i < 10; i++) cyc(1'b1, 16'(60 + i), 1'b0);
        drain(4);

        // Async reset with tokens in flight
        cyc(1'b0, 16'h0, 1'b1);
        for (int i = 0; i < 5; i++) cyc(1'b1, 16'(100 + 7 * i), 1'b0);
        #2 rstn = 1'b0;
        #1 zero_chk("async rst");
        for (int c = 0; c < NC; c++) model_clr(c);
        iv = 1'b0;
        @(posedge clk);
        @(negedge clk);
        zero_chk("in rst");
        rstn = 1'b1;
        for (int i = 0; i < 12; i++) cyc(1'b1, 16'(200 + i), 1'b0);
        drain(4);

        // Randomised stream with sparse clears
        for (int i = 0; i < 2000; i++) begin
            cyc(($urandom % 4) != 0, 16'($urandom), ($urandom % 64) == 0);
        end
        drain(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
